calc_operand_entry: RTL and testbench

//  Push-button operand-entry front end for calculator_rtl; replaces slide-switch entry on the DE2 top.

---
 rtl/calc_operand_entry_pkg.sv | 46 ++++
 rtl/calc_operand_entry_key_debounce.sv | 65 ++++++
 rtl/calc_operand_entry.sv | 142 ++++++++++++++
 tb/tb_calc_operand_entry.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_operand_entry_pkg.sv
// calc_operand_entry_pkg
//   Shared definitions for the push-button operand-entry front end:
//   operand width, default operand limit, key bit positions, field codes,
//   auto-repeat state codes and the wrap-around helpers used on num1/num2.
//   No ports; imported by calc_operand_entry and its debounce sub-module.
package calc_operand_entry_pkg;

  // Operand width matches the calculator datapath operand inputs.
  localparam int OPW             = 7;
  localparam int DEFAULT_MAX_VAL = 99;

  // Raw and synchronised key levels are active-low.
  localparam logic KEY_RELEASED = 1'b1;

  // Bit positions inside key_n.
  localparam logic [1:0] KEY_CLR = 2'd0;
  localparam logic [1:0] KEY_DEC = 2'd1;
  localparam logic [1:0] KEY_INC = 2'd2;
  localparam logic [1:0] KEY_SEL = 2'd3;

  typedef enum logic [1:0] {
    FIELD_NUM1 = 2'd0,
    FIELD_NUM2 = 2'd1,
    FIELD_CAL  = 2'd2,
    FIELD_DISP = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Values at or above the limit wrap to zero so a stray value cannot
  // escape the 0..max range.
  function automatic logic [OPW-1:0] wrap_inc(input logic [OPW-1:0] v,
                                              input logic [OPW-1:0] max_v);
    return (v >= max_v) ? '0 : v + OPW'(1);
  endfunction

  function automatic logic [OPW-1:0] wrap_dec(input logic [OPW-1:0] v,
                                              input logic [OPW-1:0] max_v);
    return ((v == '0) || (v > max_v)) ? max_v : v - OPW'(1);
  endfunction

endpackage

// File: rtl/calc_operand_entry_key_debounce.sv
// calc_operand_entry_key_debounce
//   One key input path: 2-FF synchroniser, stability counter and a
//   one-cycle press pulse on an accepted released->pressed transition.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   key_n    in   raw button, 0 = pressed
//   pressed  out  accepted (debounced) level, 1 = pressed
//   press    out  one-cycle pulse when the accepted level becomes pressed
module calc_operand_entry_key_debounce
  import calc_operand_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  // The counter only has to hold DEB_CYCLES-1 before the level flips.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_n;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= KEY_RELEASED;
      sync2 <= KEY_RELEASED;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synced level agrees with the accepted level
  // restarts the count, so a glitch shorter than DEB_CYCLES never flips it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_n <= KEY_RELEASED;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        level_n <= sync2;
        press   <= (sync2 != KEY_RELEASED);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pressed = (level_n != KEY_RELEASED);

endmodule

// File: rtl/calc_operand_entry.sv
// calc_operand_entry
//   Push-button operand-entry front end for the calculator. Four debounced
//   active-low keys edit num1/num2/cal_mode/disp_mode; inc/dec auto-repeat
//   while held.
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_n[3:0] in   raw keys, 0 = pressed: [3] select, [2] inc, [1] dec, [0] clear
//   num1       out  operand 1, 0..MAX_VAL
//   num2       out  operand 2, 0..MAX_VAL
//   cal_mode   out  operation select
//   disp_mode  out  display select
//   field_sel  out  field being edited: 0 num1, 1 num2, 2 cal_mode, 3 disp_mode
//   upd        out  one-cycle pulse whenever an edited value changes
module calc_operand_entry
  import calc_operand_entry_pkg::*;
#(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int MAX_VAL      = DEFAULT_MAX_VAL
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     key_n,
  output logic [OPW-1:0] num1,
  output logic [OPW-1:0] num2,
  output logic           cal_mode,
  output logic           disp_mode,
  output logic [1:0]     field_sel,
  output logic           upd
);

  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  // The timer expires on the cycle it reads zero, hence the -1 loads.
  localparam logic [TW-1:0]  DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  RATE_LOAD  = TW'(REPEAT_RATE - 1);
  localparam logic [OPW-1:0] MAX_V      = OPW'(MAX_VAL);

  logic [3:0]    key_level;
  logic [3:0]    key_evt;
  rpt_state_e    rpt_state;
  logic [1:0]    rpt_key;
  logic [TW-1:0] rpt_timer;
  field_e        field_q;
  logic          clr_evt;
  logic          sel_evt;
  logic          rpt_fire;
  logic          inc_evt;
  logic          dec_evt;

  for (genvar k = 0; k < 4; k++) begin : g_key
    calc_operand_entry_key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key_n[k]),
      .pressed(key_level[k]),
      .press  (key_evt[k])
    );
  end

  assign clr_evt = key_evt[KEY_CLR];
  assign sel_evt = key_evt[KEY_SEL];

  // A repeat only fires while the tracked key is still accepted as held.
  assign rpt_fire = (rpt_state != RPT_IDLE) && (rpt_timer == '0) && key_level[rpt_key];
  assign inc_evt  = key_evt[KEY_INC] | (rpt_fire & (rpt_key == KEY_INC));
  assign dec_evt  = key_evt[KEY_DEC] | (rpt_fire & (rpt_key == KEY_DEC));

  // Auto-repeat FSM. A press that loses to clear/select in the same cycle
  // does not arm the repeat; inc is tracked when inc and dec tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state <= RPT_IDLE;
      rpt_key   <= KEY_INC;
      rpt_timer <= '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          if (!clr_evt && !sel_evt && (key_evt[KEY_INC] || key_evt[KEY_DEC])) begin
            rpt_state <= RPT_WAIT;
            rpt_key   <= key_evt[KEY_INC] ? KEY_INC : KEY_DEC;
            rpt_timer <= DELAY_LOAD;
          end
        end
        RPT_WAIT, RPT_REPEAT: begin
          if (clr_evt || sel_evt || !key_level[rpt_key]) begin
            rpt_state <= RPT_IDLE;
          end else if (rpt_timer == '0) begin
            rpt_state <= RPT_REPEAT;
            rpt_timer <= RATE_LOAD;
          end else begin
            rpt_timer <= rpt_timer - TW'(1);
          end
        end
        default: rpt_state <= RPT_IDLE;
      endcase
    end
  end

  // Field registers with fixed priority clear > select > inc > dec.
  // Clear raises upd only when the field was not already zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num1      <= '0;
      num2      <= '0;
      cal_mode  <= 1'b0;
      disp_mode <= 1'b0;
      field_q   <= FIELD_NUM1;
      upd       <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (clr_evt) begin
        case (field_q)
          FIELD_NUM1: begin upd <= (num1 != '0); num1 <= '0;      end
          FIELD_NUM2: begin upd <= (num2 != '0); num2 <= '0;      end
          FIELD_CAL:  begin upd <= cal_mode;     cal_mode <= 1'b0;  end
          FIELD_DISP: begin upd <= disp_mode;    disp_mode <= 1'b0; end
          default:    upd <= 1'b0;
        endcase
      end else if (sel_evt) begin
        field_q <= field_e'(field_q + 2'd1);
      end else if (inc_evt || dec_evt) begin
        upd <= 1'b1;
        case (field_q)
          FIELD_NUM1: num1 <= inc_evt ? wrap_inc(num1, MAX_V) : wrap_dec(num1, MAX_V);
          FIELD_NUM2: num2 <= inc_evt ? wrap_inc(num2, MAX_V) : wrap_dec(num2, MAX_V);
          FIELD_CAL:  cal_mode  <= ~cal_mode;
          FIELD_DISP: disp_mode <= ~disp_mode;
          default:    upd <= 1'b0;
        endcase
      end
    end
  end

  assign field_sel = field_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// tb_calc_operand_entry
//   Self-checking bench for calc_operand_entry with short debounce and
//   repeat timings. Every expected update is queued before the keys are
//   driven; a negedge monitor pops one entry per upd pulse.
module tb_calc_operand_entry;

  localparam int DEB   = 4;
  localparam int DLY   = 20;
  localparam int RATE  = 5;
  localparam int MAXV  = 99;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_n;
  logic [6:0] num1;
  logic [6:0] num2;
  logic       cal_mode;
  logic       disp_mode;
  logic [1:0] field_sel;
  logic       upd;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] n1;
    logic [6:0] n2;
    logic       cal;
    logic       disp;
  } sb_t;

  typedef struct {
    int key;
    int fsel;
    int n1;
    int n2;
    int cal;
    int disp;
    bit upd;
  } vec_t;

  sb_t  sb[$];
  sb_t  expE;
  vec_t vecs[$];

  calc_operand_entry #(
    .DEB_CYCLES  (DEB),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE),
    .MAX_VAL     (MAXV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .num1     (num1),
    .num2     (num2),
    .cal_mode (cal_mode),
    .disp_mode(disp_mode),
    .field_sel(field_sel),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic sb_t mk(input int n1, input int n2, input int cal, input int disp);
    sb_t e;
    e.n1   = 7'(n1);
    e.n2   = 7'(n2);
    e.cal  = cal[0];
    e.disp = disp[0];
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Short press and release of one key; the hold is well under the
  // repeat delay so no auto-repeat is expected.
  task automatic applyStimulus(input int key, input bit expUpd, input sb_t expVal);
    if (expUpd) sb.push_back(expVal);
    key_n[key] = 1'b0;
    step(12);
    key_n[key] = 1'b1;
    step(12);
  endtask

  task automatic addVec(input int key, input int fsel, input int n1, input int n2,
                        input int cal, input int disp, input bit u);
    vec_t v;
    v.key = key; v.fsel = fsel; v.n1 = n1; v.n2 = n2;
    v.cal = cal; v.disp = disp; v.upd = u;
    vecs.push_back(v);
  endtask

  // Scoreboard monitor: each upd pulse must match the oldest queued value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && upd === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_upd: got upd with num1=%0d num2=%0d cal=%0b disp=%0b, expected no update",
                 num1, num2, cal_mode, disp_mode);
      end else begin
        expE = sb.pop_front();
        if ({num1, num2, cal_mode, disp_mode} !== expE) begin
          errors++;
          $display("[TB] FAIL sb_update: got num1=%0d num2=%0d cal=%0b disp=%0b, expected num1=%0d num2=%0d cal=%0b disp=%0b",
                   num1, num2, cal_mode, disp_mode, expE.n1, expE.n2, expE.cal, expE.disp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_n = 4'hF;
    step(3);
    checkOutput("reset_num1", num1, 0);
    checkOutput("reset_num2", num2, 0);
    checkOutput("reset_cal", cal_mode, 0);
    checkOutput("reset_disp", disp_mode, 0);
    checkOutput("reset_field", field_sel, 0);
    checkOutput("reset_upd", upd, 0);
    rst_n = 1'b1;
    step(2);

    // Glitch of three synced cycles must not be accepted.
    key_n[2] = 1'b0;
    step(3);
    key_n[2] = 1'b1;
    step(15);
    checkOutput("glitch_num1", num1, 0);

    // Held press: num1 changes on the 7th edge after driving (2 sync + DEB + 1).
    sb.push_back(mk(1, 0, 0, 0));
    key_n[2] = 1'b0;
    step(6);
    checkOutput("latency_before", num1, 0);
    step(1);
    checkOutput("latency_at", num1, 1);
    checkOutput("latency_upd", upd, 1);
    key_n[2] = 1'b1;
    step(12);

    // key: 0 clear, 1 dec, 2 inc, 3 select
    addVec(1, 0,  0,  0, 0, 0, 1);
    addVec(1, 0, 99,  0, 0, 0, 1);
    addVec(2, 0,  0,  0, 0, 0, 1);
    addVec(0, 0,  0,  0, 0, 0, 0);
    addVec(2, 0,  1,  0, 0, 0, 1);
    addVec(2, 0,  2,  0, 0, 0, 1);
    addVec(3, 1,  2,  0, 0, 0, 0);
    addVec(1, 1,  2, 99, 0, 0, 1);
    addVec(2, 1,  2,  0, 0, 0, 1);
    addVec(2, 1,  2,  1, 0, 0, 1);
    addVec(3, 2,  2,  1, 0, 0, 0);
    addVec(2, 2,  2,  1, 1, 0, 1);
    addVec(1, 2,  2,  1, 0, 0, 1);
    addVec(2, 2,  2,  1, 1, 0, 1);
    addVec(3, 3,  2,  1, 1, 0, 0);
    addVec(2, 3,  2,  1, 1, 1, 1);
    addVec(0, 3,  2,  1, 1, 0, 1);
    addVec(3, 0,  2,  1, 1, 0, 0);
    addVec(2, 0,  3,  1, 1, 0, 1);
    addVec(2, 0,  4,  1, 1, 0, 1);
    addVec(2, 0,  5,  1, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].key, vecs[i].upd,
                    mk(vecs[i].n1, vecs[i].n2, vecs[i].cal, vecs[i].disp));
      checkOutput($sformatf("vec%0d_field", i), field_sel, vecs[i].fsel);
      checkOutput($sformatf("vec%0d_num1", i), num1, vecs[i].n1);
      checkOutput($sformatf("vec%0d_num2", i), num2, vecs[i].n2);
      checkOutput($sformatf("vec%0d_cal", i), cal_mode, vecs[i].cal);
      checkOutput($sformatf("vec%0d_disp", i), disp_mode, vecs[i].disp);
    end

    // Auto-repeat from num1=5: +1 at edge 7, then edges 27,32,...,72.
    for (int v = 6; v <= 16; v++) sb.push_back(mk(v, 1, 1, 0));
    key_n[2] = 1'b0;
    step(26);
    checkOutput("rpt_before_delay", num1, 6);
    step(1);
    checkOutput("rpt_first", num1, 7);
    step(40);
    checkOutput("rpt_running", num1, 15);
    key_n[2] = 1'b1;
    step(5);
    checkOutput("rpt_last", num1, 16);
    step(30);
    checkOutput("rpt_stopped", num1, 16);

    // Move to num2 and bring it to 7.
    applyStimulus(3, 1'b0, mk(16, 1, 1, 0));
    checkOutput("sim_field", field_sel, 1);
    for (int i = 0; i < 6; i++) applyStimulus(2, 1'b1, mk(16, i + 2, 1, 0));
    checkOutput("sim_num2_pre", num2, 7);

    // Inc and clear accepted together: clear wins, no repeat follows.
    sb.push_back(mk(16, 0, 1, 0));
    key_n = 4'b1010;
    step(50);
    checkOutput("sim_num2", num2, 0);
    checkOutput("sim_num1", num1, 16);
    key_n = 4'hF;
    step(12);

    // Back to num1, hold dec, then select during the hold.
    for (int i = 0; i < 3; i++) applyStimulus(3, 1'b0, mk(0, 0, 0, 0));
    checkOutput("hold_field_pre", field_sel, 0);
    sb.push_back(mk(15, 0, 1, 0));
    key_n[1] = 1'b0;
    step(10);
    key_n[3] = 1'b0;
    step(50);
    checkOutput("hold_field", field_sel, 1);
    checkOutput("hold_num1", num1, 15);
    checkOutput("hold_num2", num2, 0);
    key_n = 4'hF;
    step(12);

    // Reset mid-hold once num1 has reached 42.
    for (int i = 0; i < 3; i++) applyStimulus(3, 1'b0, mk(0, 0, 0, 0));
    for (int v = 16; v <= 42; v++) sb.push_back(mk(v, 0, 1, 0));
    key_n[2] = 1'b0;
    step(152);
    checkOutput("rst_hold_num1", num1, 42);
    #1;
    checkOutput("rst_sb_drained", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_num1", num1, 0);
    checkOutput("rst_async_cal", cal_mode, 0);
    checkOutput("rst_async_field", field_sel, 0);
    checkOutput("rst_async_upd", upd, 0);
    key_n = 4'hF;
    step(3);
    rst_n = 1'b1;
    step(40);
    checkOutput("rst_quiet_num1", num1, 0);
    applyStimulus(2, 1'b1, mk(1, 0, 0, 0));
    checkOutput("rst_fresh_num1", num1, 1);

    step(5);
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
